// File: rtl/unidade_controle_exp3_if.sv
// Handshake bundle between the exp3 control unit and its datapath/host.
// master drives the requests and datapath flags; slave is the control unit.
interface unidade_controle_exp3_if;
    logic       iniciar;
    logic       igual;
    logic       fim;
    logic       pausar;
    logic       zera;
    logic       carrega;
    logic       conta;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic [3:0] db_estado;

    modport master (
        output iniciar, igual, fim, pausar,
        input  zera, carrega, conta, pronto, acertou, errou, db_estado
    );

    modport slave (
        input  iniciar, igual, fim, pausar,
        output zera, carrega, conta, pronto, acertou, errou, db_estado
    );
endinterface

// File: rtl/unidade_controle_exp3.sv
// Moore control FSM sweeping a 4-bit counter until it matches the switches.
// Optional macro PAUSA_EN adds the pausa state driven by the pausar request.
module unidade_controle_exp3 #(
    parameter int unsigned N_CICLOS = 1
) (
    input logic                     clock,
    input logic                     reset,
    unidade_controle_exp3_if.slave  bus
);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        COMPARA    = 4'h2,
        PROXIMO    = 4'h3,
        ESPERA     = 4'h4,
        PAUSA      = 4'h5,
        ACERTOU    = 4'hA,
        ERROU      = 4'hE
    } estado_t;

    // The compara cycle counts as the first of N_CICLOS, so espera lasts N_CICLOS-1 cycles.
    localparam logic [7:0] ESPERA_ULTIMO = (N_CICLOS > 1) ? 8'(N_CICLOS - 2) : 8'd0;

    estado_t    estado;
    estado_t    proximo_estado;
    logic [7:0] cont_espera;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo_estado;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_espera <= 8'd0;
        end else if (estado == ESPERA) begin
            cont_espera <= cont_espera + 8'd1;
        end else begin
            cont_espera <= 8'd0;
        end
    end

    always_comb begin
        proximo_estado = estado;
        bus.zera       = 1'b0;
        bus.carrega    = 1'b0;
        bus.conta      = 1'b0;
        bus.pronto     = 1'b0;
        bus.acertou    = 1'b0;
        bus.errou      = 1'b0;
        bus.db_estado  = estado;

        case (estado)
            INICIAL: begin
                if (bus.iniciar) proximo_estado = PREPARACAO;
            end
            PREPARACAO: begin
                bus.zera       = 1'b1;
                proximo_estado = COMPARA;
            end
            COMPARA: begin
                if (bus.igual) proximo_estado = ACERTOU;
`ifdef PAUSA_EN
                else if (bus.pausar) proximo_estado = PAUSA;
`endif
                else if (N_CICLOS > 1) proximo_estado = ESPERA;
                else proximo_estado = PROXIMO;
            end
            ESPERA: begin
                if (cont_espera == ESPERA_ULTIMO) proximo_estado = PROXIMO;
            end
            PROXIMO: begin
                bus.conta = 1'b1;
                // fim means this pulse wraps the datapath from 15 back to 0.
                if (bus.fim) proximo_estado = ERROU;
                else proximo_estado = COMPARA;
            end
`ifdef PAUSA_EN
            PAUSA: begin
                if (!bus.pausar) proximo_estado = COMPARA;
            end
`endif
            ACERTOU: begin
                bus.pronto  = 1'b1;
                bus.acertou = 1'b1;
                if (bus.iniciar) proximo_estado = PREPARACAO;
            end
            ERROU: begin
                bus.pronto = 1'b1;
                bus.errou  = 1'b1;
                if (bus.iniciar) proximo_estado = PREPARACAO;
            end
            default: begin
                proximo_estado = INICIAL;
            end
        endcase
    end

endmodule
